// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: PC steering and instruction-memory load port in,
// current PC, sequential next PC and fetched instruction out.
interface if_fetch_stage_if #(
  parameter int IM_AW = 7
);
  logic              pc_src;
  logic [15:0]       branch_target;
  logic              stall;
  logic              load_en;
  logic [IM_AW-1:0]  load_addr;
  logic [15:0]       load_data;
  logic [15:0]       pc_out;
  logic [15:0]       pc_plus2;
  logic [15:0]       instr;

  modport master (
    output pc_src, branch_target, stall, load_en, load_addr, load_data,
    input  pc_out, pc_plus2, instr
  );

  modport slave (
    input  pc_src, branch_target, stall, load_en, load_addr, load_data,
    output pc_out, pc_plus2, instr
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, +2 incrementer and a word-organised
// instruction memory with asynchronous read and a synchronous load port.
module if_fetch_stage #(
  parameter int IM_AW = 7
) (
  input logic          clk,
  input logic          rst,
  if_fetch_stage_if.slave bus
);

  localparam int DEPTH = 1 << IM_AW;

  logic [15:0] pc_p0;
  logic [15:0] pc_plus2;
  logic [15:0] pc_next;
  logic [15:0] mem [DEPTH] = '{default: 16'h0000};

  // Instructions are halfword aligned, so an odd target drops bit 0.
  function automatic logic [15:0] align_target(input logic [15:0] target);
    return target & 16'hFFFE;
  endfunction

  assign pc_plus2 = pc_p0 + 16'd2;

  always_comb begin
    pc_next = pc_plus2;
    if (bus.stall)
      pc_next = pc_p0;
    else if (bus.pc_src)
      pc_next = align_target(bus.branch_target);
  end

  // PC register stage; reset overrides stall and branch selection.
  always_ff @(posedge clk) begin
    if (!rst)
      pc_p0 <= 16'h0000;
    else
      pc_p0 <= pc_next;
  end

  // Load port is independent of reset so a program can be written while held.
  always_ff @(posedge clk) begin
    if (bus.load_en)
      mem[bus.load_addr] <= bus.load_data;
  end

  assign bus.pc_out   = pc_p0;
  assign bus.pc_plus2 = pc_plus2;
  assign bus.instr    = mem[pc_p0[IM_AW:1]];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: table of per-edge vectors plus
// hand-written read-during-write and mid-run reset sequences.
module tb_if_fetch_stage;

  localparam int IM_AW = 7;

  logic clk;
  logic rst;

  if_fetch_stage_if #(.IM_AW(IM_AW)) bus ();

  if_fetch_stage #(.IM_AW(IM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        pc_src;
    logic [15:0] bt;
    logic [15:0] pc;
    logic [15:0] pp2;
    logic [15:0] ins;
  } vec_t;

  vec_t tv[$];
  int   total;
  int   passed;

  function automatic vec_t mk(input logic r, input logic s, input logic p,
                              input logic [15:0] bt, input logic [15:0] pc,
                              input logic [15:0] pp2, input logic [15:0] ins);
    vec_t v;
    v.rst = r; v.stall = s; v.pc_src = p; v.bt = bt;
    v.pc = pc; v.pp2 = pp2; v.ins = ins;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp)
      passed++;
    else
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IM_AW-1:0] a, input logic [15:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    step();
    bus.load_en   = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst               = 1'b0;
    bus.pc_src        = 1'b0;
    bus.branch_target = 16'h0000;
    bus.stall         = 1'b0;
    bus.load_en       = 1'b0;
    bus.load_addr     = '0;
    bus.load_data     = 16'h0000;

    // Preload the program while held in reset.
    load(7'd0,   16'h1111);
    load(7'd1,   16'h2222);
    load(7'd2,   16'h3333);
    load(7'd3,   16'h4444);
    load(7'd8,   16'h8888);
    load(7'd9,   16'h9999);
    load(7'd127, 16'h7F7F);

    check("reset_pc",   0, bus.pc_out,   16'h0000);
    check("reset_pp2",  0, bus.pc_plus2, 16'h0002);
    check("reset_inst", 0, bus.instr,    16'h1111);

    //                rst   stall pc_src bt         pc        pp2       instr
    tv.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h1111));
    tv.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 16'h0002, 16'h1111));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0004, 16'h2222));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0006, 16'h3333));
    tv.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0010, 16'h0012, 16'h8888));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h0014, 16'h9999));
    tv.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0006, 16'h0006, 16'h0008, 16'h4444));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0006, 16'h0008, 16'h4444));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0006, 16'h0008, 16'h4444));
    tv.push_back(mk(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0006, 16'h0008, 16'h4444));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h000A, 16'h0000));
    tv.push_back(mk(1'b1, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 16'h7F7F));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002, 16'h1111));
    tv.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0100, 16'h0102, 16'h1111));
    tv.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0102, 16'h0104, 16'h2222));
    tv.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0003, 16'h0002, 16'h0004, 16'h2222));

    for (int i = 0; i < tv.size(); i++) begin
      rst               = tv[i].rst;
      bus.stall         = tv[i].stall;
      bus.pc_src        = tv[i].pc_src;
      bus.branch_target = tv[i].bt;
      step();
      check("pc",    i, bus.pc_out,   tv[i].pc);
      check("pp2",   i, bus.pc_plus2, tv[i].pp2);
      check("instr", i, bus.instr,    tv[i].ins);
    end

    // Read-during-write to the word at the current PC (pc_out = 2, word 1).
    bus.stall     = 1'b1;
    bus.pc_src    = 1'b0;
    bus.load_en   = 1'b1;
    bus.load_addr = 7'd1;
    bus.load_data = 16'hBEEF;
    #1;
    check("rdw_before", 0, bus.instr, 16'h2222);
    step();
    check("rdw_after", 0, bus.instr,  16'hBEEF);
    check("rdw_pc",    0, bus.pc_out, 16'h0002);
    bus.load_en = 1'b0;
    bus.stall   = 1'b0;

    // Reset mid-run with a branch and a load pending.
    bus.pc_src        = 1'b1;
    bus.branch_target = 16'h000A;
    step();
    check("mid_pc_pre", 0, bus.pc_out, 16'h000A);
    rst               = 1'b0;
    bus.branch_target = 16'h0030;
    bus.load_en       = 1'b1;
    bus.load_addr     = 7'd5;
    bus.load_data     = 16'h5A5A;
    step();
    check("mid_pc_rst",  0, bus.pc_out,   16'h0000);
    check("mid_pp2_rst", 0, bus.pc_plus2, 16'h0002);
    check("mid_ins_rst", 0, bus.instr,    16'h1111);
    rst               = 1'b1;
    bus.load_en       = 1'b0;
    bus.branch_target = 16'h000A;
    step();
    check("mid_pc_after",  0, bus.pc_out, 16'h000A);
    check("mid_mem5",      0, bus.instr,  16'h5A5A);
    bus.pc_src = 1'b0;
    step();
    check("mid_seq_pc", 0, bus.pc_out, 16'h000C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
